hash_gen: RTL and testbench
===========================

# hash_gen

BLAKE3 single-block compression engine. It takes a 256-bit chaining value, a 512-bit message block, the block byte length and chunk flags, runs the 7-round BLAKE3 compression, and returns the 256-bit output chaining value. It is the hashing core of the miner datapath, fed by a block scheduler and consumed by the target comparator. IV constants come from the shared defines header (`IV_0` … `IV_7`).

## Interface
Parameters:
- none.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Rstn_I  in  1  one clock; reset is synchronous and active-low.
- Strt_I  in  1  start pulse; samples all inputs below when idle.
- BL_I  in  32  block length in bytes (0–64).
- CS_flg_I  in  1  CHUNK_START flag (bit 0 of flags word).
- CE_flg_I  in  1  CHUNK_END flag (bit 1).
- ROOT_flg_I  in  1  ROOT flag (bit 3).
- H_I  in  8×32 (packed [7:0][31:0])  input chaining value, word 0 = H_I[0].
- Msg0_I … Msg15_I  in  32 each  message words m0..m15, little-endian words.
- Vld_O  out  1  one-cycle pulse: H0_O..H7_O updated.
- H0_O … H7_O  out  32 each  output chaining value words.

## Operation
- States: IDLE, RUN (round counter 0..6).
- IDLE + Strt_I=1: latch message m0..m15; init state v0..v7=H_I, v8..v11=IV0..IV3 (6A09E667, BB67AE85, 3C6EF372, A54FF53A), v12=counter low, v13=counter high, v14=BL_I, v15={28'b0, ROOT, 1'b0 (PARENT), CE, CS}; latch H_I as hin; go RUN, round=0.
- RUN: each cycle one full round: column G on (0,4,8,12,m0,m1),(1,5,9,13,m2,m3),(2,6,10,14,m4,m5),(3,7,11,15,m6,m7); then diagonal G on (0,5,10,15,m8,m9),(1,6,11,12,m10,m11),(2,7,8,13,m12,m13),(3,4,9,14,m14,m15); then permute message registers: new m[i]=old m[P[i]], P = 2,6,3,10,7,0,4,13,1,11,12,5,9,14,15,8.
- G(a,b,c,d,x,y): a+=b+x; d=(d^a)>>>16; c+=d; b=(b^c)>>>12; a+=b+y; d=(d^a)>>>8; c+=d; b=(b^c)>>>7. All adds mod 2^32, >>> is rotate right.
- After round 6: Hi_O = v[i] ^ v[i+8] (i=0..7), Vld_O=1 for one cycle, return IDLE.
- Strt_I while RUN is ignored; inputs may change freely after the start cycle.
- H0_O..H7_O hold their value until the next completion.

## Timing
- Reset (Rstn_I=0 at an edge): state IDLE, Vld_O=0, H0_O..H7_O=0, round counter 0. Reset mid-RUN aborts; no Vld_O produced.
- Latency: Strt_I sampled at edge E; rounds at edges E+1..E+7; Vld_O high and outputs valid in the cycle after edge E+7 (7 cycles start→valid).
- Back-to-back: Strt_I in the Vld_O cycle is accepted (state already IDLE); throughput one block per 8 cycles.
- Vld_O is never high for more than one consecutive cycle per job.

## Configuration
- HASHGEN_COUNTER_EN defined: adds input port Cnt_I (64 bits, after ROOT_flg_I); v12=Cnt_I[31:0], v13=Cnt_I[63:32], latched on start.
- Not defined: no Cnt_I port; v12=v13=0 (chunk counter 0, single-chunk mode).

## Test plan
- Empty input: H_I=IV, all Msg=0, BL_I=0, CS=CE=ROOT=1 -> Vld_O pulse 7 cycles after Strt_I; H0..H7 = B94913AF, A6A1F9F5, EA4D40A0, 49C9DC36, C925CB9B, B712C1AD, CA939ACC, 62321FE4.
- Reset: Rstn_I=0 one cycle -> Vld_O=0, all Hx_O=0; repeat empty vector -> same digest.
- Repeat start: two Strt_I pulses 100 cycles apart with identical inputs -> two Vld_O pulses, identical digests, outputs stable between.
- Start while busy: Strt_I at E and E+3 -> exactly one Vld_O pulse (after edge E+7).
- Reset mid-run: Rstn_I=0 at E+4 -> no Vld_O, outputs 0; next start completes normally.
- Flags/length: same message with ROOT=0 or BL_I=64 -> digest differs from empty-input result and matches reference BLAKE3 compression model.

Source files
------------

// File: rtl/hash_gen_if.sv
// Start/message/digest bundle for the hash_gen BLAKE3 compression core.
// With HASHGEN_COUNTER_EN defined, the bundle also carries the 64-bit chunk counter Cnt_I.
interface hash_gen_if;
  logic            Strt_I;
  logic [31:0]     BL_I;
  logic            CS_flg_I;
  logic            CE_flg_I;
  logic            ROOT_flg_I;
`ifdef HASHGEN_COUNTER_EN
  logic [63:0]     Cnt_I;
`endif
  logic [7:0][31:0] H_I;
  logic [31:0]     Msg0_I, Msg1_I, Msg2_I, Msg3_I, Msg4_I, Msg5_I, Msg6_I, Msg7_I;
  logic [31:0]     Msg8_I, Msg9_I, Msg10_I, Msg11_I, Msg12_I, Msg13_I, Msg14_I, Msg15_I;
  logic            Vld_O;
  logic [31:0]     H0_O, H1_O, H2_O, H3_O, H4_O, H5_O, H6_O, H7_O;

  modport master (
    output Strt_I, BL_I, CS_flg_I, CE_flg_I, ROOT_flg_I,
`ifdef HASHGEN_COUNTER_EN
    output Cnt_I,
`endif
    output H_I,
    output Msg0_I, Msg1_I, Msg2_I, Msg3_I, Msg4_I, Msg5_I, Msg6_I, Msg7_I,
    output Msg8_I, Msg9_I, Msg10_I, Msg11_I, Msg12_I, Msg13_I, Msg14_I, Msg15_I,
    input  Vld_O, H0_O, H1_O, H2_O, H3_O, H4_O, H5_O, H6_O, H7_O
  );

  modport slave (
    input  Strt_I, BL_I, CS_flg_I, CE_flg_I, ROOT_flg_I,
`ifdef HASHGEN_COUNTER_EN
    input  Cnt_I,
`endif
    input  H_I,
    input  Msg0_I, Msg1_I, Msg2_I, Msg3_I, Msg4_I, Msg5_I, Msg6_I, Msg7_I,
    input  Msg8_I, Msg9_I, Msg10_I, Msg11_I, Msg12_I, Msg13_I, Msg14_I, Msg15_I,
    output Vld_O, H0_O, H1_O, H2_O, H3_O, H4_O, H5_O, H6_O, H7_O
  );
endinterface

// File: rtl/hash_gen.sv
// BLAKE3 single-block compression: one full round per cycle, 7 rounds, truncated 256-bit output CV.
// Optional HASHGEN_COUNTER_EN: chunk counter taken from Cnt_I instead of fixed zero.
`ifndef IV_0
`define IV_0 32'h6A09E667
`endif
`ifndef IV_1
`define IV_1 32'hBB67AE85
`endif
`ifndef IV_2
`define IV_2 32'h3C6EF372
`endif
`ifndef IV_3
`define IV_3 32'hA54FF53A
`endif

module hash_gen (
  input logic       Clk,
  input logic       Rstn_I,
  hash_gen_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] PERM [16] = '{4'd2, 4'd6, 4'd3, 4'd10, 4'd7, 4'd0, 4'd4, 4'd13,
                                       4'd1, 4'd11, 4'd12, 4'd5, 4'd9, 4'd14, 4'd15, 4'd8};

  state_t            state;
  logic [2:0]        round;
  logic [15:0][31:0] v, m, v_next, m_next;
  logic [7:0][31:0]  h_out;
  logic              vld;
  logic [63:0]       cnt;
  logic [31:0]       flags;

`ifdef HASHGEN_COUNTER_EN
  assign cnt = bus.Cnt_I;
`else
  assign cnt = '0;
`endif

  assign flags = {28'd0, bus.ROOT_flg_I, 1'b0, bus.CE_flg_I, bus.CS_flg_I};

  // Returns {a, b, c, d} after one quarter-round mix.
  function automatic logic [127:0] g(input logic [31:0] a, b, c, d, x, y);
    a = a + b + x;
    d = d ^ a;  d = {d[15:0], d[31:16]};
    c = c + d;
    b = b ^ c;  b = {b[11:0], b[31:12]};
    a = a + b + y;
    d = d ^ a;  d = {d[7:0], d[31:8]};
    c = c + d;
    b = b ^ c;  b = {b[6:0], b[31:7]};
    return {a, b, c, d};
  endfunction

  always_comb begin
    v_next = v;
    {v_next[0], v_next[4], v_next[8],  v_next[12]} = g(v_next[0], v_next[4], v_next[8],  v_next[12], m[0],  m[1]);
    {v_next[1], v_next[5], v_next[9],  v_next[13]} = g(v_next[1], v_next[5], v_next[9],  v_next[13], m[2],  m[3]);
    {v_next[2], v_next[6], v_next[10], v_next[14]} = g(v_next[2], v_next[6], v_next[10], v_next[14], m[4],  m[5]);
    {v_next[3], v_next[7], v_next[11], v_next[15]} = g(v_next[3], v_next[7], v_next[11], v_next[15], m[6],  m[7]);
    {v_next[0], v_next[5], v_next[10], v_next[15]} = g(v_next[0], v_next[5], v_next[10], v_next[15], m[8],  m[9]);
    {v_next[1], v_next[6], v_next[11], v_next[12]} = g(v_next[1], v_next[6], v_next[11], v_next[12], m[10], m[11]);
    {v_next[2], v_next[7], v_next[8],  v_next[13]} = g(v_next[2], v_next[7], v_next[8],  v_next[13], m[12], m[13]);
    {v_next[3], v_next[4], v_next[9],  v_next[14]} = g(v_next[3], v_next[4], v_next[9],  v_next[14], m[14], m[15]);
    m_next = m;
    for (int unsigned i = 0; i < 16; i++) m_next[i] = m[PERM[i]];
  end

  always_ff @(posedge Clk) begin
    if (!Rstn_I) begin
      state <= IDLE;
      round <= '0;
      vld   <= 1'b0;
      h_out <= '0;
    end else begin
      vld <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Strt_I) begin
            m <= {bus.Msg15_I, bus.Msg14_I, bus.Msg13_I, bus.Msg12_I,
                  bus.Msg11_I, bus.Msg10_I, bus.Msg9_I,  bus.Msg8_I,
                  bus.Msg7_I,  bus.Msg6_I,  bus.Msg5_I,  bus.Msg4_I,
                  bus.Msg3_I,  bus.Msg2_I,  bus.Msg1_I,  bus.Msg0_I};
            v <= {flags, bus.BL_I, cnt[63:32], cnt[31:0],
                  `IV_3, `IV_2, `IV_1, `IV_0, bus.H_I};
            round <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          v <= v_next;
          m <= m_next;
          // Final round: the output CV is taken straight from the freshly mixed state.
          if (round == 3'd6) begin
            for (int unsigned i = 0; i < 8; i++) h_out[i] <= v_next[i] ^ v_next[i+8];
            vld   <= 1'b1;
            round <= '0;
            state <= IDLE;
          end else begin
            round <= round + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Vld_O = vld;
  assign bus.H0_O  = h_out[0];
  assign bus.H1_O  = h_out[1];
  assign bus.H2_O  = h_out[2];
  assign bus.H3_O  = h_out[3];
  assign bus.H4_O  = h_out[4];
  assign bus.H5_O  = h_out[5];
  assign bus.H6_O  = h_out[6];
  assign bus.H7_O  = h_out[7];

endmodule

// File: tb/tb_hash_gen.sv
// Scoreboard bench for hash_gen: directed BLAKE3 vectors plus a small reference compression model.
module tb_hash_gen;
  typedef logic [7:0][31:0]  dig_t;
  typedef logic [15:0][31:0] msg_t;
  typedef struct { dig_t d; int unsigned cyc; } exp_t;

  localparam dig_t IV    = {32'h5BE0CD19, 32'h1F83D9AB, 32'h9B05688C, 32'h510E527F,
                            32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667};
  localparam dig_t EMPTY = {32'h62321FE4, 32'hCA939ACC, 32'hB712C1AD, 32'hC925CB9B,
                            32'h49C9DC36, 32'hEA4D40A0, 32'hA6A1F9F5, 32'hB94913AF};
  localparam dig_t ABC   = {32'h859DBDD5, 32'h6C9C35FD, 32'h03DB795D, 32'h4658C548,
                            32'hB58D3A27, 32'h753BB6FF, 32'h33514638, 32'hACB33764};
  localparam int unsigned GA [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  localparam int unsigned GB [8] = '{4, 5, 6, 7, 5, 6, 7, 4};
  localparam int unsigned GC [8] = '{8, 9, 10, 11, 10, 11, 8, 9};
  localparam int unsigned GD [8] = '{12, 13, 14, 15, 15, 12, 13, 14};
  localparam int unsigned SIGMA [16] = '{2, 6, 3, 10, 7, 0, 4, 13, 1, 11, 12, 5, 9, 14, 15, 8};

  logic clk = 1'b0;
  logic rstn = 1'b0;
  hash_gen_if bus();
  hash_gen dut (.Clk(clk), .Rstn_I(rstn), .bus(bus));
  always #5 clk = ~clk;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned vld_count = 0;
  logic        prev_vld = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic dig_t ref_compress(input dig_t h, input msg_t msg, input logic [31:0] bl,
                                        input logic [31:0] flags);
    logic [31:0] s [16];
    logic [31:0] mm [16];
    logic [31:0] t [16];
    int unsigned a, b, c, d;
    dig_t r;
    for (int i = 0; i < 8; i++) s[i] = h[i];
    for (int i = 0; i < 4; i++) s[i+8] = IV[i];
    s[12] = 32'd0; s[13] = 32'd0; s[14] = bl; s[15] = flags;
    for (int i = 0; i < 16; i++) mm[i] = msg[i];
    for (int rd = 0; rd < 7; rd++) begin
      for (int k = 0; k < 8; k++) begin
        a = GA[k]; b = GB[k]; c = GC[k]; d = GD[k];
        s[a] = s[a] + s[b] + mm[2*k];
        s[d] = rotr(s[d] ^ s[a], 16);
        s[c] = s[c] + s[d];
        s[b] = rotr(s[b] ^ s[c], 12);
        s[a] = s[a] + s[b] + mm[2*k+1];
        s[d] = rotr(s[d] ^ s[a], 8);
        s[c] = s[c] + s[d];
        s[b] = rotr(s[b] ^ s[c], 7);
      end
      for (int i = 0; i < 16; i++) t[i] = mm[SIGMA[i]];
      mm = t;
    end
    for (int i = 0; i < 8; i++) r[i] = s[i] ^ s[i+8];
    return r;
  endfunction

  function automatic dig_t get_h();
    return {bus.H7_O, bus.H6_O, bus.H5_O, bus.H4_O, bus.H3_O, bus.H2_O, bus.H1_O, bus.H0_O};
  endfunction

  task automatic set_msg(input msg_t x);
    bus.Msg0_I  = x[0];  bus.Msg1_I  = x[1];  bus.Msg2_I  = x[2];  bus.Msg3_I  = x[3];
    bus.Msg4_I  = x[4];  bus.Msg5_I  = x[5];  bus.Msg6_I  = x[6];  bus.Msg7_I  = x[7];
    bus.Msg8_I  = x[8];  bus.Msg9_I  = x[9];  bus.Msg10_I = x[10]; bus.Msg11_I = x[11];
    bus.Msg12_I = x[12]; bus.Msg13_I = x[13]; bus.Msg14_I = x[14]; bus.Msg15_I = x[15];
  endtask

  // Called at a falling edge; returns at the falling edge after the start was sampled.
  task automatic start_job(input dig_t h, input msg_t x, input logic [31:0] bl, input logic [2:0] fl,
                           input dig_t exp, input bit expect_out);
    msg_t junk;
    bus.H_I = h;
    set_msg(x);
    bus.BL_I = bl;
    {bus.ROOT_flg_I, bus.CE_flg_I, bus.CS_flg_I} = fl;
    bus.Strt_I = 1'b1;
    if (expect_out) sb.push_back('{exp, cyc + 8});
    @(negedge clk);
    bus.Strt_I = 1'b0;
    for (int i = 0; i < 16; i++) junk[i] = $urandom;
    set_msg(junk);
    bus.H_I  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    bus.BL_I = $urandom;
    {bus.ROOT_flg_I, bus.CE_flg_I, bus.CS_flg_I} = 3'($urandom);
  endtask

  task automatic wait_drain(input string name);
    int unsigned n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s_timeout: actual %0d pending results required 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Monitor: pops the scoreboard on every valid pulse, checks digest and latency.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.Vld_O === 1'b1) begin
        vld_count++;
        check("vld_single", 256'(prev_vld), 256'(0));
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_vld: actual Vld_O=1 at cycle %0d required no pulse", cyc);
        end else begin
          e = sb.pop_front();
          check("digest", get_h(), e.d);
          check("latency", 256'(cyc), 256'(e.cyc));
        end
      end
      prev_vld = bus.Vld_O;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual simulation still running required completion");
    $fatal(1);
  end

  initial begin
    msg_t zero_msg, abc_msg, pat_msg;
    dig_t exp_d, pat_h, hold;
    int unsigned vc0, n;
    bit stable;
    zero_msg = '0;
    abc_msg = '0;
    abc_msg[0] = 32'h00636261;
    for (int i = 0; i < 16; i++) pat_msg[i] = 32'h01010101 * i + 32'h80402010;
    pat_h = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
             32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};

    bus.Strt_I = 1'b0;
    bus.BL_I = '0;
    bus.CS_flg_I = 1'b0; bus.CE_flg_I = 1'b0; bus.ROOT_flg_I = 1'b0;
`ifdef HASHGEN_COUNTER_EN
    bus.Cnt_I = '0;
`endif
    bus.H_I = '0;
    set_msg(zero_msg);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    check("reset_vld", 256'(bus.Vld_O), 256'(0));
    check("reset_h", get_h(), '0);

    // Empty input
    start_job(IV, zero_msg, 32'd0, 3'b111, EMPTY, 1'b1);
    wait_drain("empty");

    // One-cycle reset, then repeat
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    check("reset2_vld", 256'(bus.Vld_O), 256'(0));
    check("reset2_h", get_h(), '0);
    start_job(IV, zero_msg, 32'd0, 3'b111, EMPTY, 1'b1);
    wait_drain("empty_after_reset");

    // Outputs hold between jobs, then an identical second job
    hold = get_h();
    stable = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (get_h() !== hold || bus.Vld_O !== 1'b0) stable = 1'b0;
    end
    check("hold_stable", 256'(stable), 256'(1));
    start_job(IV, zero_msg, 32'd0, 3'b111, EMPTY, 1'b1);
    wait_drain("repeat");

    // Start while busy at E+3 with different inputs must be ignored
    @(negedge clk);
    vc0 = vld_count;
    start_job(IV, zero_msg, 32'd0, 3'b111, EMPTY, 1'b1);
    repeat (2) @(negedge clk);
    start_job(pat_h, pat_msg, 32'd64, 3'b011, '0, 1'b0);
    wait_drain("busy");
    repeat (12) @(negedge clk);
    check("busy_one_vld", 256'(vld_count - vc0), 256'(1));

    // Reset asserted at E+4 aborts the job
    vc0 = vld_count;
    start_job(IV, zero_msg, 32'd0, 3'b111, EMPTY, 1'b0);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("abort_h", get_h(), '0);
    repeat (12) @(negedge clk);
    check("abort_no_vld", 256'(vld_count - vc0), 256'(0));
    check("abort_h_held", get_h(), '0);
    start_job(IV, zero_msg, 32'd0, 3'b111, EMPTY, 1'b1);
    wait_drain("after_abort");

    // "abc" then a start in the valid cycle
    @(negedge clk);
    start_job(IV, abc_msg, 32'd3, 3'b111, ABC, 1'b1);
    n = 0;
    while (bus.Vld_O !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    start_job(IV, zero_msg, 32'd0, 3'b111, EMPTY, 1'b1);
    wait_drain("back_to_back");

    // Flags and length variants
    exp_d = ref_compress(IV, zero_msg, 32'd0, 32'h3);
    start_job(IV, zero_msg, 32'd0, 3'b011, exp_d, 1'b1);
    wait_drain("root0");
    tests++;
    if (get_h() === EMPTY) begin
      fails++;
      $display("FAIL root0_differs: actual %h required a value other than %h", get_h(), EMPTY);
    end

    exp_d = ref_compress(IV, zero_msg, 32'd64, 32'hB);
    start_job(IV, zero_msg, 32'd64, 3'b111, exp_d, 1'b1);
    wait_drain("bl64");
    tests++;
    if (get_h() === EMPTY) begin
      fails++;
      $display("FAIL bl64_differs: actual %h required a value other than %h", get_h(), EMPTY);
    end

    exp_d = ref_compress(pat_h, pat_msg, 32'd64, 32'h1);
    start_job(pat_h, pat_msg, 32'd64, 3'b001, exp_d, 1'b1);
    wait_drain("pattern");

    repeat (12) @(negedge clk);
    check("no_pending", 256'(sb.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
